// File: rtl/layer_sample_driver.sv
// Producer-side driver for a neuron_learn layer: buffers samples, issues one at a
// time with a single valid pulse, and returns the captured layer response.
module layer_sample_driver #(
  parameter int unsigned N       = 16,
  parameter int unsigned M       = 41,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ZW      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_learn,
  input  logic [N-1:0][ZW-1:0]    s_in,
  input  logic [M-1:0][ZW-1:0]    s_expected,
  output logic                    layer_valid,
  output logic                    layer_learn,
  output logic [N-1:0][ZW-1:0]    layer_in,
  output logic [M-1:0][ZW-1:0]    layer_expected_out,
  input  logic [M-1:0][ZW-1:0]    layer_out,
  input  logic [N-1:0][ZW-1:0]    layer_expected_in,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    r_learn,
  output logic [M-1:0][ZW-1:0]    r_out,
  output logic [N-1:0][ZW-1:0]    r_expected_in,
  output logic                    busy,
  output logic [CNT_W-1:0]        learn_count,
  output logic [CNT_W-1:0]        infer_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

  state_t                  state, state_next;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic [LW-1:0]           lat_cnt;
  logic                    push, pop, fifo_empty, capture;

  logic                    mem_learn [DEPTH];
  logic [N-1:0][ZW-1:0]    mem_in    [DEPTH];
  logic [M-1:0][ZW-1:0]    mem_exp   [DEPTH];

  // s_ready uses the registered count, so a full FIFO refuses even while popping
  assign s_ready    = (count < CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = s_valid && s_ready;
  assign pop        = (state == IDLE) && run && !fifo_empty;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_learn[wr_ptr] <= s_learn;
      mem_in[wr_ptr]    <= s_in;
      mem_exp[wr_ptr]   <= s_expected;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE:   if (run && !fifo_empty) state_next = ISSUE;
      ISSUE:  state_next = WAIT;
      WAIT: begin
        if (lat_cnt == LW'(LATENCY - 1)) begin
          capture    = 1'b1;
          state_next = REPORT;
        end
      end
      REPORT: if (r_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      layer_learn        <= 1'b0;
      layer_in           <= '0;
      layer_expected_out <= '0;
      r_learn            <= 1'b0;
      r_out              <= '0;
      r_expected_in      <= '0;
      learn_count        <= '0;
      infer_count        <= '0;
      lat_cnt            <= '0;
    end else begin
      if (pop) begin
        layer_learn        <= mem_learn[rd_ptr];
        layer_in           <= mem_in[rd_ptr];
        layer_expected_out <= mem_exp[rd_ptr];
      end
      if (state == ISSUE) begin
        lat_cnt <= '0;
        if (layer_learn) begin
          if (learn_count != '1) learn_count <= learn_count + CNT_W'(1);
        end else begin
          if (infer_count != '1) infer_count <= infer_count + CNT_W'(1);
        end
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + LW'(1);
      end
      if (capture) begin
        r_out         <= layer_out;
        r_expected_in <= layer_expected_in;
        r_learn       <= layer_learn;
      end
    end
  end

  assign layer_valid = (state == ISSUE);
  assign r_valid     = (state == REPORT);
  assign busy        = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_layer_sample_driver.sv
// Scoreboard bench for layer_sample_driver: dut0 has LATENCY=1/CNT_W=16,
// dut1 has LATENCY=3/CNT_W=2; a layer model adds the cycles since valid to its outputs.
module tb_layer_sample_driver;
  localparam int N  = 16;
  localparam int M  = 41;
  localparam int ZW = 8;

  typedef logic [N-1:0][ZW-1:0] vin_t;
  typedef logic [M-1:0][ZW-1:0] vout_t;
  typedef struct { logic learn; vout_t out; vin_t ein; } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst;
  logic  run [2], s_valid [2], s_learn [2], r_ready [2];
  logic  s_ready [2], layer_valid [2], layer_learn [2], r_valid [2], r_learn [2], busy [2];
  vin_t  s_in [2], layer_in [2], layer_ein [2], r_ein [2];
  vout_t s_exp [2], layer_eout [2], layer_out [2], r_out [2];
  logic [15:0] lc0, ic0;
  logic [1:0]  lc1, ic1;
  logic [7:0]  cyc [2];

  res_t sb0[$], sb1[$];
  int assertions = 0;
  int failures   = 0;
  int results [2] = '{0, 0};

  layer_sample_driver #(.N(N), .M(M), .DEPTH(4), .LATENCY(1), .CNT_W(16), .ZW(ZW)) dut0 (
    .clock(clk), .reset(rst), .run(run[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_learn(s_learn[0]), .s_in(s_in[0]), .s_expected(s_exp[0]),
    .layer_valid(layer_valid[0]), .layer_learn(layer_learn[0]), .layer_in(layer_in[0]),
    .layer_expected_out(layer_eout[0]), .layer_out(layer_out[0]), .layer_expected_in(layer_ein[0]),
    .r_valid(r_valid[0]), .r_ready(r_ready[0]), .r_learn(r_learn[0]), .r_out(r_out[0]),
    .r_expected_in(r_ein[0]), .busy(busy[0]), .learn_count(lc0), .infer_count(ic0));

  layer_sample_driver #(.N(N), .M(M), .DEPTH(4), .LATENCY(3), .CNT_W(2), .ZW(ZW)) dut1 (
    .clock(clk), .reset(rst), .run(run[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_learn(s_learn[1]), .s_in(s_in[1]), .s_expected(s_exp[1]),
    .layer_valid(layer_valid[1]), .layer_learn(layer_learn[1]), .layer_in(layer_in[1]),
    .layer_expected_out(layer_eout[1]), .layer_out(layer_out[1]), .layer_expected_in(layer_ein[1]),
    .r_valid(r_valid[1]), .r_ready(r_ready[1]), .r_learn(r_learn[1]), .r_out(r_out[1]),
    .r_expected_in(r_ein[1]), .busy(busy[1]), .learn_count(lc1), .infer_count(ic1));

  // Layer model: outputs drift by one each cycle after the valid pulse, so the
  // captured value reveals exactly which cycle was sampled.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst)                               cyc[d] <= 8'd0;
      else if (layer_valid[d])               cyc[d] <= 8'd1;
      else if (cyc[d] != 0 && cyc[d] != 255) cyc[d] <= cyc[d] + 8'd1;
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < M; j++) layer_out[d][j] = layer_eout[d][j] + 8'(j) + cyc[d];
      for (int i = 0; i < N; i++) layer_ein[d][i] = (layer_in[d][i] ^ {layer_learn[d], 7'd0}) + cyc[d];
    end
  end

  function automatic res_t model(int d, logic l, vin_t in, vout_t e);
    res_t r;
    int lat = (d == 0) ? 1 : 3;
    r.learn = l;
    for (int j = 0; j < M; j++) r.out[j] = e[j] + 8'(j) + 8'(lat);
    for (int i = 0; i < N; i++) r.ein[i] = (in[i] ^ {l, 7'd0}) + 8'(lat);
    return r;
  endfunction

  function automatic vin_t rin();
    vin_t v;
    for (int i = 0; i < N; i++) v[i] = 8'($urandom);
    return v;
  endfunction

  function automatic vout_t rout();
    vout_t v;
    for (int j = 0; j < M; j++) v[j] = 8'($urandom);
    return v;
  endfunction

  function automatic int sb_size(int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        for (int d = 0; d < 2; d++) begin
          if (r_valid[d] && r_ready[d]) begin
            results[d]++;
            assertions++;
            if (sb_size(d) == 0) begin
              failures++;
              $display("FAIL unexpected_result dut%0d: r_valid=1 with nothing expected", d);
            end else begin
              e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
              if (r_learn[d] !== e.learn || r_out[d] !== e.out || r_ein[d] !== e.ein) begin
                failures++;
                $display("FAIL result dut%0d: got learn=%b out=%h ein=%h, expected learn=%b out=%h ein=%h",
                         d, r_learn[d], r_out[d], r_ein[d], e.learn, e.out, e.ein);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      run[d] = 1'b0; s_valid[d] = 1'b0; s_learn[d] = 1'b0; r_ready[d] = 1'b0;
      s_in[d] = '0; s_exp[d] = '0;
    end
    sb0.delete(); sb1.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Single attempt; leaves s_valid asserted so consecutive calls are back-to-back.
  task automatic push(input int d, input logic l, input vin_t in, input vout_t e, output bit acc);
    s_valid[d] = 1'b1; s_learn[d] = l; s_in[d] = in; s_exp[d] = e;
    @(negedge clk);
    acc = s_ready[d];
    if (acc) begin
      if (d == 0) sb0.push_back(model(d, l, in, e));
      else        sb1.push_back(model(d, l, in, e));
    end
    @(posedge clk); #1;
  endtask

  task automatic push_wait(input int d, input logic l, input vin_t in, input vout_t e);
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) push(d, l, in, e, acc);
    s_valid[d] = 1'b0;
    assertions++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout dut%0d: accepted=%b required=1", d, acc);
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = !busy[d] && !r_valid[d] && sb_size(d) == 0;
      @(posedge clk); #1;
    end
    assertions++;
    if (!done) begin
      failures++;
      $display("FAIL idle_timeout dut%0d: busy=%b pending=%0d required idle", d, busy[d], sb_size(d));
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      assertions++;
      if ({s_ready[d], layer_valid[d], layer_learn[d], r_valid[d], r_learn[d], busy[d]} !== 6'b100000) begin
        failures++;
        $display("FAIL reset_flags dut%0d: got %b required 100000", d,
                 {s_ready[d], layer_valid[d], layer_learn[d], r_valid[d], r_learn[d], busy[d]});
      end
      assertions++;
      if (layer_in[d] !== '0 || layer_eout[d] !== '0 || r_out[d] !== '0 || r_ein[d] !== '0) begin
        failures++;
        $display("FAIL reset_vectors dut%0d: layer_in=%h r_ein=%h required zero", d, layer_in[d], r_ein[d]);
      end
    end
    assertions++;
    if (lc0 !== 16'd0 || ic0 !== 16'd0 || lc1 !== 2'd0 || ic1 !== 2'd0) begin
      failures++;
      $display("FAIL reset_counters: got %0d/%0d/%0d/%0d required 0/0/0/0", lc0, ic0, lc1, ic1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    vin_t in; vout_t e, leo; vin_t lin;
    int issue_c = -1, rv_c = -1, vcnt = 0;
    logic llearn = 1'b0, rl = 1'b0;
    bit acc;
    for (int i = 0; i < N; i++) in[i] = 8'h80;
    for (int j = 0; j < M; j++) e[j] = 8'hFF;
    do_reset();
    run[0] = 1'b1; r_ready[0] = 1'b1;
    push(0, 1'b1, in, e, acc);
    s_valid[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (layer_valid[0]) begin
        vcnt++;
        if (issue_c < 0) begin
          issue_c = c; llearn = layer_learn[0]; lin = layer_in[0]; leo = layer_eout[0];
        end
      end
      if (r_valid[0] && rv_c < 0) begin rv_c = c; rl = r_learn[0]; end
      @(posedge clk); #1;
    end
    assertions++;
    if (issue_c !== 1) begin failures++; $display("FAIL single_issue_cycle: got %0d required 1", issue_c); end
    assertions++;
    if (vcnt !== 1) begin failures++; $display("FAIL single_valid_width: got %0d required 1", vcnt); end
    assertions++;
    if (llearn !== 1'b1 || lin !== in || leo !== e) begin
      failures++; $display("FAIL single_operands: learn=%b in=%h required learn=1 in=%h", llearn, lin, in);
    end
    assertions++;
    if (rv_c - issue_c !== 2 || rl !== 1'b1) begin
      failures++; $display("FAIL single_result_latency: got %0d learn=%b required 2 learn=1", rv_c - issue_c, rl);
    end
    assertions++;
    if (lc0 !== 16'd1 || ic0 !== 16'd0) begin
      failures++; $display("FAIL single_counters: got %0d/%0d required 1/0", lc0, ic0);
    end
    assertions++;
    if (layer_in[0] !== in || busy[0] !== 1'b0) begin
      failures++; $display("FAIL single_hold_after: layer_in=%h busy=%b required %h busy=0", layer_in[0], busy[0], in);
    end
  endtask

  task automatic test_back_to_back();
    bit acc [5];
    logic [4:0] accv;
    int r0;
    do_reset();
    r_ready[0] = 1'b1;
    r0 = results[0];
    for (int k = 0; k < 5; k++) push(0, logic'(k % 2), rin(), rout(), acc[k]);
    s_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) accv[k] = acc[k];
    assertions++;
    if (accv !== 5'b01111) begin failures++; $display("FAIL b2b_accept: got %b required 01111", accv); end
    @(negedge clk);
    assertions++;
    if (s_ready[0] !== 1'b0 || busy[0] !== 1'b1 || layer_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full: s_ready=%b busy=%b layer_valid=%b required 0 1 0", s_ready[0], busy[0], layer_valid[0]);
    end
    @(posedge clk); #1;
    run[0] = 1'b1;
    wait_idle(0, 100);
    assertions++;
    if (results[0] - r0 !== 4) begin failures++; $display("FAIL b2b_count: got %0d required 4", results[0] - r0); end
  endtask

  task automatic test_hold();
    vin_t a1, a2, lin; vout_t e1, e2, sv_out; vin_t sv_ein;
    bit found = 1'b0;
    int bad = 0, iss = -1;
    a1 = rin(); a2 = rin(); e1 = rout(); e2 = rout();
    do_reset();
    run[0] = 1'b1;
    push_wait(0, 1'b1, a1, e1);
    push_wait(0, 1'b0, a2, e2);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (r_valid[0]) begin found = 1'b1; sv_out = r_out[0]; sv_ein = r_ein[0]; end
      @(posedge clk); #1;
    end
    assertions++;
    if (!found) begin failures++; $display("FAIL hold_first_result: r_valid=%b required 1", r_valid[0]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!r_valid[0] || r_out[0] !== sv_out || r_ein[0] !== sv_ein || layer_valid[0] || layer_in[0] !== a1) bad++;
      @(posedge clk); #1;
    end
    assertions++;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
    r_ready[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (layer_valid[0] && iss < 0) begin iss = c; lin = layer_in[0]; end
      @(posedge clk); #1;
    end
    assertions++;
    if (iss !== 2 || lin !== a2) begin
      failures++; $display("FAIL hold_next_issue: cycle=%0d in=%h required cycle=2 in=%h", iss, lin, a2);
    end
    wait_idle(0, 50);
  endtask

  task automatic test_latency();
    int iss[$], rvq[$];
    bit bad = 1'b0;
    do_reset();
    run[1] = 1'b1; r_ready[1] = 1'b1;
    fork
      for (int k = 0; k < 4; k++) push_wait(1, logic'((k % 2) == 0), rin(), rout());
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (layer_valid[1]) iss.push_back(c);
        if (r_valid[1])     rvq.push_back(c);
      end
    join
    @(posedge clk); #1;
    assertions++;
    if (iss.size() !== 4 || rvq.size() !== 4) begin
      failures++; $display("FAIL lat_counts: issues=%0d results=%0d required 4/4", iss.size(), rvq.size());
      bad = 1'b1;
    end
    if (!bad) begin
      for (int k = 0; k < 4; k++) begin
        assertions++;
        if (rvq[k] - iss[k] !== 4) begin
          failures++; $display("FAIL lat_result_delay[%0d]: got %0d required 4", k, rvq[k] - iss[k]);
        end
        if (k > 0) begin
          assertions++;
          if (iss[k] - iss[k-1] !== 6) begin
            failures++; $display("FAIL lat_issue_spacing[%0d]: got %0d required 6", k, iss[k] - iss[k-1]);
          end
        end
      end
    end
    wait_idle(1, 50);
    assertions++;
    if (lc1 !== 2'd2 || ic1 !== 2'd2) begin failures++; $display("FAIL lat_counters: got %0d/%0d required 2/2", lc1, ic1); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0, f;
    int bad = 0;
    do_reset();
    r_ready[0] = 1'b1;
    for (int k = 0; k < 3; k++) push_wait(0, 1'b1, rin(), rout());
    run[0] = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk); f = layer_valid[0];
      @(posedge clk); #1;
      found = f;
    end
    rst = 1'b1;
    sb0.delete();
    @(negedge clk);
    assertions++;
    if (!found || layer_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL mid_in_wait: issued=%b layer_valid=%b busy=%b required 1 0 1", found, layer_valid[0], busy[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    assertions++;
    if ({s_ready[0], layer_valid[0], layer_learn[0], r_valid[0], r_learn[0], busy[0]} !== 6'b100000 ||
        layer_in[0] !== '0 || layer_eout[0] !== '0 || r_out[0] !== '0 || r_ein[0] !== '0 || lc0 !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_state: flags=%b learn_count=%0d required 100000 and 0",
               {s_ready[0], layer_valid[0], layer_learn[0], r_valid[0], r_learn[0], busy[0]}, lc0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (r_valid[0] || layer_valid[0] || busy[0]) bad++;
      @(posedge clk); #1;
    end
    assertions++;
    if (bad !== 0) begin failures++; $display("FAIL mid_no_activity: got %0d active cycles required 0", bad); end
  endtask

  task automatic test_saturate();
    int r1;
    do_reset();
    run[1] = 1'b1; r_ready[1] = 1'b1;
    r1 = results[1];
    for (int k = 0; k < 5; k++) push_wait(1, 1'b1, rin(), rout());
    wait_idle(1, 100);
    assertions++;
    if (lc1 !== 2'd3 || ic1 !== 2'd0 || results[1] - r1 !== 5) begin
      failures++;
      $display("FAIL sat_counter: learn=%0d infer=%0d results=%0d required 3/0/5", lc1, ic1, results[1] - r1);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      run[d] = 1'b0; s_valid[d] = 1'b0; s_learn[d] = 1'b0; r_ready[d] = 1'b0;
      s_in[d] = '0; s_exp[d] = '0;
    end
    fork monitor(); join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_latency();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d failures so far", failures);
    $fatal(1, "watchdog expired");
  end

endmodule
